// File: rtl/axi_mem_responder.sv
// AXI4 memory responder with one transaction in flight, backed by a word array at address 0.
// Define PANTHER_AXI_MEM_WSTRB_EN to honour wstrb_i byte enables; otherwise whole words are written.
module axi_mem_responder #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int MEM_WORDS      = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [AXI_ID_WIDTH-1:0]       awid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     awaddr_i,
  input  logic [7:0]                    awlen_i,
  input  logic [2:0]                    awsize_i,
  input  logic [1:0]                    awburst_i,
  input  logic                          awvalid_i,
  output logic                          awready_o,
  input  logic [AXI_DATA_WIDTH-1:0]     wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]   wstrb_i,
  input  logic                          wlast_i,
  input  logic                          wvalid_i,
  output logic                          wready_o,
  output logic [AXI_ID_WIDTH-1:0]       bid_o,
  output logic [1:0]                    bresp_o,
  output logic                          bvalid_o,
  input  logic                          bready_i,
  input  logic [AXI_ID_WIDTH-1:0]       arid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     araddr_i,
  input  logic [7:0]                    arlen_i,
  input  logic [2:0]                    arsize_i,
  input  logic [1:0]                    arburst_i,
  input  logic                          arvalid_i,
  output logic                          arready_o,
  output logic [AXI_ID_WIDTH-1:0]       rid_o,
  output logic [AXI_DATA_WIDTH-1:0]     rdata_o,
  output logic [1:0]                    rresp_o,
  output logic                          rlast_o,
  output logic                          rvalid_o,
  input  logic                          rready_i
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(STRB_W);
  localparam logic [AXI_ADDR_WIDTH-1:0] MEM_LIMIT = AXI_ADDR_WIDTH'(MEM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_e;

  state_e                      state_q, state_d;
  logic                        init_q;
  logic [AXI_ID_WIDTH-1:0]     id_q, id_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]                  len_q, len_d, cnt_q, cnt_d;
  logic [1:0]                  burst_q, burst_d;
  logic                        slv_q, slv_d, dec_q, dec_d;
  logic                        bvalid_q, bvalid_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [AXI_ID_WIDTH-1:0]     bid_q, bid_d, rid_q, rid_d;
  logic [1:0]                  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [AXI_DATA_WIDTH-1:0]   mem_q [MEM_WORDS];
  logic                        mem_we;
  logic [IDX_W-1:0]            mem_idx;

  logic [AXI_ADDR_WIDTH-1:0]   rd_addr;
  logic [1:0]                  rd_burst;
  logic [1:0]                  rd_resp;
  logic [AXI_DATA_WIDTH-1:0]   rd_data;
  logic                        beat_last, beat_in_range;
  logic                        unused_ok;

  function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                                          input logic [1:0] burst);
    return (burst == BURST_INCR) ? addr + ADDR_STEP : addr;
  endfunction

  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return (addr >> OFF_W) < MEM_LIMIT;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return IDX_W'(addr >> OFF_W);
  endfunction

  // Sizes are ignored (always full-width beats); byte enables only matter with the strobe build.
`ifdef PANTHER_AXI_MEM_WSTRB_EN
  assign unused_ok = ^{awsize_i, arsize_i};
`else
  assign unused_ok = ^{awsize_i, arsize_i, wstrb_i};
`endif

  // The beat about to be presented: the AR request itself in IDLE, the stored address otherwise.
  always_comb begin
    rd_addr  = (state_q == S_IDLE) ? araddr_i  : addr_q;
    rd_burst = (state_q == S_IDLE) ? arburst_i : burst_q;
    if (!in_range(rd_addr))  rd_resp = RESP_DECERR;
    else if (rd_burst[1])    rd_resp = RESP_SLVERR;
    else                     rd_resp = RESP_OKAY;
    rd_data = (rd_resp == RESP_OKAY) ? mem_q[word_idx(rd_addr)] : '0;
  end

  assign beat_last     = (cnt_q == len_q);
  assign beat_in_range = in_range(addr_q);
  assign mem_idx       = word_idx(addr_q);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    burst_d   = burst_q;
    slv_d     = slv_q;
    dec_d     = dec_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    mem_we    = 1'b0;
    awready_o = 1'b0;
    arready_o = 1'b0;
    wready_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        awready_o = init_q;
        // A pending write blocks AR acceptance so no read handshake is ever dropped.
        arready_o = init_q && !awvalid_i;
        if (awvalid_i && awready_o) begin
          id_d    = awid_i;
          addr_d  = awaddr_i;
          len_d   = awlen_i;
          burst_d = awburst_i;
          cnt_d   = '0;
          slv_d   = awburst_i[1];
          dec_d   = 1'b0;
          state_d = S_WDATA;
        end else if (arvalid_i && arready_o) begin
          len_d    = arlen_i;
          burst_d  = arburst_i;
          addr_d   = next_addr(araddr_i, arburst_i);
          cnt_d    = '0;
          rvalid_d = 1'b1;
          rid_d    = arid_i;
          rdata_d  = rd_data;
          rresp_d  = rd_resp;
          rlast_d  = (arlen_i == 8'd0);
          state_d  = S_RDATA;
        end
      end
      S_WDATA: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          mem_we = !burst_q[1] && beat_in_range;
          dec_d  = dec_q | !beat_in_range;
          slv_d  = slv_q | (wlast_i != beat_last);
          addr_d = next_addr(addr_q, burst_q);
          cnt_d  = cnt_q + 8'd1;
          if (beat_last) begin
            state_d  = S_WRESP;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = dec_d ? RESP_DECERR : (slv_d ? RESP_SLVERR : RESP_OKAY);
          end
        end
      end
      S_WRESP: begin
        if (bready_i) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_RDATA: begin
        if (rready_i) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = S_IDLE;
          end else begin
            rdata_d = rd_data;
            rresp_d = rd_resp;
            cnt_d   = cnt_q + 8'd1;
            rlast_d = ((cnt_q + 8'd1) == len_q);
            addr_d  = next_addr(addr_q, burst_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      init_q   <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      burst_q  <= '0;
      slv_q    <= 1'b0;
      dec_q    <= 1'b0;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      init_q   <= 1'b1;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      burst_q  <= burst_d;
      slv_q    <= slv_d;
      dec_q    <= dec_d;
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
    end
  end

  // NOTE: the array has no reset; its contents survive rst_ni and it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
`ifdef PANTHER_AXI_MEM_WSTRB_EN
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) mem_q[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
`else
      mem_q[mem_idx] <= wdata_i;
`endif
    end
  end

  assign bvalid_o = bvalid_q;
  assign bid_o    = bid_q;
  assign bresp_o  = bresp_q;
  assign rvalid_o = rvalid_q;
  assign rid_o    = rid_q;
  assign rdata_o  = rdata_q;
  assign rresp_o  = rresp_q;
  assign rlast_o  = rlast_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomised self-checking bench for axi_mem_responder against a word-array reference model.
module tb_axi_mem_responder;
  localparam int MW = 1024;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [7:0]  awid_i, arid_i, bid_o, rid_o;
  logic [31:0] awaddr_i, araddr_i, wdata_i, rdata_o;
  logic [7:0]  awlen_i, arlen_i;
  logic [2:0]  awsize_i, arsize_i;
  logic [1:0]  awburst_i, arburst_i, bresp_o, rresp_o;
  logic        awvalid_i, awready_o, wlast_i, wvalid_i, wready_o, bvalid_o, bready_i;
  logic        arvalid_i, arready_o, rlast_o, rvalid_o, rready_i;
  logic [3:0]  wstrb_i;

  axi_mem_responder dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain word array plus a written-flag per word.
  logic [31:0] model_mem [MW];
  bit          model_vld [MW];

  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  int          wlast_bad;
  logic [31:0] rdat [256];
  logic [1:0]  rrsp [256];
  logic        rlst [256];

  function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [1:0] burst, input int i);
    return (burst == 2'b01) ? addr + 32'(4 * i) : addr;
  endfunction

  task automatic model_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             output logic [1:0] exp);
    bit oob = 0;
    bit slv = burst[1] || (wlast_bad >= 0 && wlast_bad <= len);
    for (int i = 0; i <= len; i++) begin
      logic [31:0] a = beat_addr(addr, burst, i);
      int idx = int'(a >> 2);
      if (a >= 32'(4 * MW)) oob = 1;
      else if (!burst[1]) begin
`ifdef PANTHER_AXI_MEM_WSTRB_EN
        for (int b = 0; b < 4; b++)
          if (sbuf[i][b]) model_mem[idx][8*b +: 8] = wbuf[i][8*b +: 8];
`else
        model_mem[idx] = wbuf[i];
`endif
        model_vld[idx] = 1;
      end
    end
    exp = oob ? 2'b11 : (slv ? 2'b10 : 2'b00);
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, output logic [1:0] resp, output int b_cyc);
    int n;
    logic [7:0] hid;
    logic [1:0] hresp;
    awid_i = id; awaddr_i = addr; awlen_i = 8'(len); awburst_i = burst;
    awsize_i = 3'd2; awvalid_i = 1'b1;
    n = 0;
    while (!awready_o && n < 200) begin @(posedge clk); #1; n++; end
    check("awready", 64'(awready_o), 64'd1);
    @(posedge clk); #1;
    awvalid_i = 1'b0;
    wvalid_i = 1'b1;
    for (int i = 0; i <= len; i++) begin
      wdata_i = wbuf[i]; wstrb_i = sbuf[i];
      wlast_i = (i == len) ^ (i == wlast_bad);
      n = 0;
      while (!wready_o && n < 200) begin @(posedge clk); #1; n++; end
      if (n >= 200) check("wready_timeout", 64'(n), 64'd0);
      @(posedge clk); #1;
    end
    wvalid_i = 1'b0; wlast_i = 1'b0;
    n = 0;
    while (!bvalid_o && n < 200) begin @(posedge clk); #1; n++; end
    check("bvalid", 64'(bvalid_o), 64'd1);
    check("bid", 64'(bid_o), 64'(id));
    hid = bid_o; hresp = bresp_o;
    @(posedge clk); #1;
    check("b_hold", 64'({bvalid_o, bid_o, bresp_o}), 64'({1'b1, hid, hresp}));
    resp = bresp_o;
    bready_i = 1'b1;
    @(posedge clk); #1;
    b_cyc = cyc;
    bready_i = 1'b0;
    check("b_drop", 64'(bvalid_o), 64'd0);
  endtask

  // mode 0: rready always 1, 1: random, 2: pattern 1,0,0,1 repeating
  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input int mode, output int ar_cyc);
    int n, got, k;
    bit stalled;
    logic [31:0] hd;
    logic [1:0]  hr;
    logic        hl;
    arid_i = id; araddr_i = addr; arlen_i = 8'(len); arburst_i = burst;
    arsize_i = 3'd2; arvalid_i = 1'b1;
    n = 0;
    while (!arready_o && n < 200) begin @(posedge clk); #1; n++; end
    check("arready", 64'(arready_o), 64'd1);
    @(posedge clk); #1;
    ar_cyc = cyc;
    arvalid_i = 1'b0;
    check("rvalid_first", 64'(rvalid_o), 64'd1);
    got = 0; k = 0; n = 0; stalled = 0;
    hd = '0; hr = '0; hl = 1'b0;
    while (got <= len && n < 2000) begin
      rready_i = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1))
                                    : 1'((k % 4 == 0) || (k % 4 == 3));
      k++;
      if (stalled) check("r_hold", 64'({rvalid_o, rlast_o, rresp_o, rdata_o}), 64'({1'b1, hl, hr, hd}));
      if (rvalid_o) begin hd = rdata_o; hr = rresp_o; hl = rlast_o; end
      if (rvalid_o && rready_i) begin
        check("rid", 64'(rid_o), 64'(id));
        rdat[got] = rdata_o; rrsp[got] = rresp_o; rlst[got] = rlast_o;
        got++;
      end
      stalled = rvalid_o && !rready_i;
      @(posedge clk); #1; n++;
    end
    rready_i = 1'b0;
    check("r_beats", 64'(got), 64'(len + 1));
    check("r_done", 64'(rvalid_o), 64'd0);
  endtask

  task automatic check_read(input logic [31:0] addr, input int len, input logic [1:0] burst);
    for (int i = 0; i <= len; i++) begin
      logic [31:0] a = beat_addr(addr, burst, i);
      logic [1:0] er = (a >= 32'(4 * MW)) ? 2'b11 : (burst[1] ? 2'b10 : 2'b00);
      check("rresp", 64'(rrsp[i]), 64'(er));
      check("rlast", 64'(rlst[i]), 64'(i == len));
      if (er == 2'b11) check("rdata_oob", 64'(rdat[i]), 64'd0);
      else if (er == 2'b00 && model_vld[int'(a >> 2)])
        check("rdata", 64'(rdat[i]), 64'(model_mem[int'(a >> 2)]));
    end
  endtask

  task automatic wr_and_check(input logic [7:0] id, input logic [31:0] addr, input int len,
                              input logic [1:0] burst, input string tag);
    logic [1:0] resp, exp;
    int bc;
    do_write(id, addr, len, burst, resp, bc);
    model_write(addr, len, burst, exp);
    check(tag, 64'(resp), 64'(exp));
  endtask

  task automatic rd_and_check(input logic [7:0] id, input logic [31:0] addr, input int len,
                              input logic [1:0] burst, input int mode);
    int ac;
    do_read(id, addr, len, burst, mode, ac);
    check_read(addr, len, burst);
  endtask

  initial begin
    logic [1:0] resp, exp;
    int b_cyc, ar_cyc;
    rst_ni = 1'b0;
    {awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i} = '0;
    {wdata_i, wstrb_i, wlast_i, wvalid_i, bready_i} = '0;
    {arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i, rready_i} = '0;
    wlast_bad = -1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_readys", 64'({awready_o, arready_o, wready_o}), 64'd0);
    check("rst_valids", 64'({bvalid_o, rvalid_o, rlast_o}), 64'd0);
    check("rst_values", 64'({bid_o, bresp_o, rid_o, rresp_o, rdata_o}), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 64'({awready_o, arready_o}), 64'b11);

    // Preload words 0..255 so random reads always hit known data.
    for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    wr_and_check(8'h01, 32'h0, 255, 2'b01, "preload_bresp");

    // Basic INCR write then read.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    wr_and_check(8'h12, 32'h10, 3, 2'b01, "incr_bresp");
    rd_and_check(8'h13, 32'h10, 3, 2'b01, 0);
    check("incr_word4", 64'(rdat[0]), 64'hA0);
    check("incr_word7", 64'(rdat[3]), 64'hA3);

    // Simultaneous AW and AR: write wins, read sees the new data.
    wbuf[0] = 32'hCAFE0000; wbuf[1] = 32'hCAFE0001;
    fork
      do_write(8'h05, 32'h40, 1, 2'b01, resp, b_cyc);
      begin #2; do_read(8'h06, 32'h40, 1, 2'b01, 0, ar_cyc); end
    join
    model_write(32'h40, 1, 2'b01, exp);
    check("prio_bresp", 64'(resp), 64'(exp));
    check("prio_b_before_ar", 64'(ar_cyc > b_cyc), 64'd1);
    check_read(32'h40, 1, 2'b01);

    // Read with rready stalls 1,0,0,1.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h5500 + 32'(i);
    wr_and_check(8'h21, 32'h100, 3, 2'b01, "stall_bresp");
    rd_and_check(8'h22, 32'h100, 3, 2'b01, 2);

    // Out-of-range access.
    wbuf[0] = 32'hDEADBEEF;
    wr_and_check(8'h31, 32'h1000, 0, 2'b01, "oob_bresp");
    rd_and_check(8'h32, 32'h1000, 0, 2'b01, 0);
    rd_and_check(8'h33, 32'h0, 0, 2'b01, 0);

    // WRAP burst: SLVERR and no write; early wlast: SLVERR, all beats accepted.
    wbuf[0] = 32'h0BAD0000; wbuf[1] = 32'h0BAD0001;
    wr_and_check(8'h41, 32'h200, 1, 2'b10, "wrap_bresp");
    rd_and_check(8'h42, 32'h200, 1, 2'b01, 0);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h7700 + 32'(i);
    wlast_bad = 1;
    wr_and_check(8'h43, 32'h300, 3, 2'b01, "early_wlast_bresp");
    wlast_bad = -1;
    rd_and_check(8'h44, 32'h300, 3, 2'b01, 0);

    // Byte strobes.
    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    wr_and_check(8'h51, 32'h50, 0, 2'b01, "strb_init_bresp");
    wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'b0101;
    wr_and_check(8'h52, 32'h50, 0, 2'b01, "strb_bresp");
    rd_and_check(8'h53, 32'h50, 0, 2'b01, 0);
`ifdef PANTHER_AXI_MEM_WSTRB_EN
    check("strb_result", 64'(rdat[0]), 64'h11FF33FF);
`else
    check("strb_result", 64'(rdat[0]), 64'hFFFFFFFF);
`endif

    // Randomised traffic against the model.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      int len = $urandom_range(0, 7);
      logic [1:0] burst = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 5) == 0) ? 32'(4 * $urandom_range(1018, 1030))
                                      : 32'(4 * $urandom_range(0, 240));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
        wlast_bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
        wr_and_check(8'($urandom), a, len, burst, "rand_bresp");
        wlast_bad = -1;
      end else begin
        rd_and_check(8'($urandom), a, len, burst, 1);
      end
    end

    // Reset in the middle of a read burst.
    arid_i = 8'h77; araddr_i = 32'h0; arlen_i = 8'd7; arburst_i = 2'b01; arvalid_i = 1'b1;
    begin
      int n = 0;
      while (!arready_o && n < 200) begin @(posedge clk); #1; n++; end
    end
    @(posedge clk); #1;
    arvalid_i = 1'b0; rready_i = 1'b1;
    @(posedge clk); #1;
    rready_i = 1'b0;
    check("mid_rvalid", 64'(rvalid_o), 64'd1);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    check("midrst_readys", 64'({awready_o, arready_o, wready_o}), 64'd0);
    check("midrst_valids", 64'({bvalid_o, rvalid_o, rlast_o}), 64'd0);
    check("midrst_values", 64'({bid_o, bresp_o, rid_o, rresp_o, rdata_o}), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    check("ready_after_midrst", 64'({awready_o, arready_o}), 64'b11);
    rd_and_check(8'h78, 32'h100, 3, 2'b01, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
